mont_result_collector: RTL

- Downstream stage of the pipelined Montgomery multiplier PE chain.
- Accepts the word-serial result S, least-significant word first, as produced by the last PE (S1_new/S0_new word stream).
- Reassembles S into a full-width register and applies the final conditional subtraction (S >= M ? S-M : S), word-serially with a borrow chain.
- Presents the reduced product on a valid/ready output to the next consumer, such as the exponentiation controller.

---
 rtl/mont_pkg.sv | 22 ++
 rtl/mont_word_sub.sv | 18 +
 rtl/mont_result_collector.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery result collector: FSM states, default
// widths and the word-count derivation.
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SUB     = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  localparam int DW_DEF = 12;
  localparam int W_DEF  = 6;

  // ceil((dw+1)/w): one spare bit so the redundant 2M-1 range fits
  function automatic int calc_nw(input int dw, input int w);
    return (dw + w) / w;
  endfunction

  localparam int NW_DEF = calc_nw(DW_DEF, W_DEF);

endpackage

// File: rtl/mont_word_sub.sv
// One word of the borrow-chain subtract: {bout, d} = a - b - bin on w+1 bits.
module mont_word_sub #(
  parameter int w = 6
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         bin,
  output logic [w-1:0] d,
  output logic         bout
);

  logic [w:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{w{1'b0}}, bin};
  assign d    = full[w-1:0];
  assign bout = full[w];

endmodule

// File: rtl/mont_result_collector.sv
// Collects the word-serial Montgomery result S and optionally applies the
// final S >= M ? S-M : S reduction. Feature macro: MONT_FINAL_SUB_EN.
module mont_result_collector
  import mont_pkg::*;
#(
  parameter int dw = DW_DEF,
  parameter int w  = W_DEF,
  parameter int nw = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] m_in,
  input  logic          s_valid,
  input  logic [w-1:0]  s_word,
  output logic          s_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [dw-1:0] res,
  output logic          res_sub
);

  localparam int SW = nw * w;
  localparam int CW = (nw > 1) ? $clog2(nw) : 1;
  localparam logic [CW-1:0] LAST = CW'(nw - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   s_q, s_d;
  logic [dw-1:0]   res_q, res_d;
  logic            res_sub_q, res_sub_d;
  logic            res_valid_q, res_valid_d;

  logic [SW-1:0]   m_ext;
  logic [w-1:0]    sub_a, sub_b, sub_d;
  logic            sub_bin, sub_bout;

  assign m_ext = {{(SW - dw){1'b0}}, m_in};
  assign sub_a = s_q[cnt_q * w +: w];
  assign sub_b = m_ext[cnt_q * w +: w];

  // Single subtractor, stepped across the words by cnt_q during SUB
  mont_word_sub #(.w(w)) u_word_sub (
    .a    (sub_a),
    .b    (sub_b),
    .bin  (sub_bin),
    .d    (sub_d),
    .bout (sub_bout)
  );

`ifdef MONT_FINAL_SUB_EN
  logic [SW-1:0] diff_q, diff_d;
  logic          borrow_q, borrow_d;

  assign sub_bin = borrow_q;
`else
  logic unused_sub;

  assign sub_bin    = 1'b0;
  assign unused_sub = ^{sub_d, sub_bout};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    res_d       = res_q;
    res_sub_d   = res_sub_q;
    res_valid_d = res_valid_q;
`ifdef MONT_FINAL_SUB_EN
    diff_d      = diff_q;
    borrow_d    = borrow_q;
`endif
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (s_valid) begin
          s_d[cnt_q * w +: w] = s_word;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef MONT_FINAL_SUB_EN
            state_d  = ST_SUB;
            borrow_d = 1'b0;
`else
            state_d     = ST_OUT;
            res_d       = s_d[dw-1:0];
            res_sub_d   = 1'b0;
            res_valid_d = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_COLLECT;
          end
        end
      end
`ifdef MONT_FINAL_SUB_EN
      ST_SUB: begin
        diff_d[cnt_q * w +: w] = sub_d;
        borrow_d               = sub_bout;
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = ST_OUT;
          res_valid_d = 1'b1;
          // No final borrow means S >= M, so the difference is the result
          if (!sub_bout) begin
            res_d     = diff_d[dw-1:0];
            res_sub_d = 1'b1;
          end else begin
            res_d     = s_q[dw-1:0];
            res_sub_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_q         <= '0;
      res_q       <= '0;
      res_sub_q   <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef MONT_FINAL_SUB_EN
      diff_q      <= '0;
      borrow_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      res_q       <= res_d;
      res_sub_q   <= res_sub_d;
      res_valid_q <= res_valid_d;
`ifdef MONT_FINAL_SUB_EN
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
`endif
    end
  end

  assign s_ready   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign res_sub   = res_sub_q;

endmodule
